// File: rtl/capp_pkg.sv
// Shared types for the associative processor.
//   op_e    : command encoding presented on op_code
//   state_e : command sequencing state
package capp_pkg;

    typedef enum logic [2:0] {
        NOP      = 3'd0,
        SET_ALL  = 3'd1,
        CLR_TAGS = 3'd2,
        SEARCH   = 3'd3,
        SEL_FST  = 3'd4,
        READ     = 3'd5,
        WRITE    = 3'd6,
        LOAD     = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/capp_first_resp.sv
// Lowest-set-bit encoder over the tag vector.
//   i_vec     in   WORDS   vector to scan
//   o_any     out  1       at least one bit set
//   o_index   out  IDX_W   index of lowest set bit (0 if none)
//   o_onehot  out  WORDS   one-hot of lowest set bit (0 if none)
module capp_first_resp #(
    parameter int WORDS = 64,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic [WORDS-1:0] i_vec,
    output logic             o_any,
    output logic [IDX_W-1:0] o_index,
    output logic [WORDS-1:0] o_onehot
);

    always_comb begin
        o_any    = |i_vec;
        o_index  = '0;
        // Two's-complement trick isolates the lowest set bit.
        o_onehot = i_vec & (~i_vec + WORDS'(1));
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/capp_engine.sv
// Associative processor: cell storage, tag register, comparand/mask search,
// select-first, masked multi-write and addressed load behind one command
// handshake, with responder summary on the response side.
//   CLK, RST                   clock, synchronous active-high reset
//   op_valid/op_ready          command handshake
//   op_code                    capp_pkg::op_e
//   comparand, mask, wdata     operands (mask: 1 = bit participates/written)
//   addr                       cell index for LOAD
//   rsp_valid/rsp_ready        response handshake
//   rsp_data                   first responder word for READ, else 0
//   rsp_any/index/count        summary of tags after the op
//   tags                       live tag register
//
// state | meaning
// IDLE  | ready for a command, fields captured on accept
// EXEC  | captured op applied to cells/tags at the end of this cycle
// RESP  | response presented, held until rsp_ready
module capp_engine
    import capp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WORDS = 64,
    parameter int IDX_W = $clog2(WORDS),
    parameter int CNT_W = $clog2(WORDS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] comparand,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_any,
    output logic [IDX_W-1:0] rsp_index,
    output logic [CNT_W-1:0] rsp_count,
    output logic [WORDS-1:0] tags
);

    state_e           r_state;
    state_e           w_next_state;

    logic [WIDTH-1:0] r_cells [WORDS];
    logic [WORDS-1:0] r_tags;
    op_e              r_op;
    logic [WIDTH-1:0] r_cmp;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_wdata;
    logic [IDX_W-1:0] r_addr;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_accept;
    logic             w_in_resp;
    logic             w_first_any;
    logic [IDX_W-1:0] w_first_idx;
    logic [WORDS-1:0] w_first_onehot;
    logic [CNT_W-1:0] w_count;

    // Tags never change outside EXEC, so a single encoder on the live tags
    // serves SEL_FST/READ during EXEC and the response summary during RESP.
    capp_first_resp #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_first_resp (
        .i_vec    (r_tags),
        .o_any    (w_first_any),
        .o_index  (w_first_idx),
        .o_onehot (w_first_onehot)
    );

    always_comb begin
        w_count = '0;
        for (int i = 0; i < WORDS; i++) begin
            w_count = w_count + CNT_W'(r_tags[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        op_ready     = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept  = op_valid && op_ready;
    assign w_in_resp = (r_state == RESP);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < WORDS; i++) begin
                r_cells[i] <= '0;
            end
            r_tags     <= '0;
            r_op       <= NOP;
            r_cmp      <= '0;
            r_mask     <= '0;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= op_e'(op_code);
                r_cmp   <= comparand;
                r_mask  <= mask;
                r_wdata <= wdata;
                r_addr  <= addr;
            end

            if (w_in_resp && rsp_ready) begin
                r_rsp_data <= '0;
            end

            if (r_state == EXEC) begin
                r_rsp_data <= '0;
                case (r_op)
                    SET_ALL: r_tags <= '1;
                    CLR_TAGS: r_tags <= '0;
                    SEARCH: begin
                        for (int i = 0; i < WORDS; i++) begin
                            r_tags[i] <= r_tags[i] &
                                (((r_cells[i] ^ r_cmp) & r_mask) == '0);
                        end
                    end
                    SEL_FST: r_tags <= w_first_onehot;
                    READ: begin
                        if (w_first_any) begin
                            r_rsp_data <= r_cells[w_first_idx];
                        end
                    end
                    WRITE: begin
                        for (int i = 0; i < WORDS; i++) begin
                            if (r_tags[i]) begin
                                r_cells[i] <= (r_cells[i] & ~r_mask) |
                                              (r_wdata & r_mask);
                            end
                        end
                    end
                    LOAD: begin
                        // Only reachable when WORDS is not a power of two.
                        if (32'(r_addr) < WORDS) begin
                            r_cells[r_addr] <= r_wdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rsp_data  = r_rsp_data;
    assign rsp_any   = w_in_resp & w_first_any;
    assign rsp_index = w_in_resp ? w_first_idx : '0;
    assign rsp_count = w_in_resp ? w_count : '0;
    assign tags      = r_tags;

endmodule

// File: tb/tb_capp_engine.sv
module tb_capp_engine;
    import capp_pkg::*;

    localparam int WIDTH = 32;
    localparam int WORDS = 64;
    localparam int IDX_W = 6;
    localparam int CNT_W = 7;
    localparam logic [63:0] ALL = '1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] comparand;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] wdata;
    logic [IDX_W-1:0] addr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_any;
    logic [IDX_W-1:0] rsp_index;
    logic [CNT_W-1:0] rsp_count;
    logic [WORDS-1:0] tags;

    capp_engine #(
        .WIDTH (WIDTH),
        .WORDS (WORDS),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .comparand (comparand),
        .mask      (mask),
        .wdata     (wdata),
        .addr      (addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_any   (rsp_any),
        .rsp_index (rsp_index),
        .rsp_count (rsp_count),
        .tags      (tags)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        op_e         op;
        logic [31:0] cmp;
        logic [31:0] msk;
        logic [31:0] wd;
        logic [5:0]  ad;
        logic [63:0] e_tags;
        int          e_cnt;
        int          e_idx;
        logic        e_any;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    logic [63:0] s_tags;
    logic [31:0] s_data;
    int          s_cnt;
    int          s_idx;
    logic        s_any;
    int          s_lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    function automatic void add(input op_e op, input logic [31:0] cmp, input logic [31:0] msk,
                                input logic [31:0] wd, input logic [5:0] ad,
                                input logic [63:0] t, input int c, input int ix,
                                input logic a, input logic [31:0] d);
        vec_t v;
        v.op = op; v.cmp = cmp; v.msk = msk; v.wd = wd; v.ad = ad;
        v.e_tags = t; v.e_cnt = c; v.e_idx = ix; v.e_any = a; v.e_data = d;
        vecs.push_back(v);
    endfunction

    // Issue one op with rsp_ready held high; sample the response at the
    // falling edge where rsp_valid is first seen.
    task automatic do_op(input op_e op, input logic [31:0] cmp, input logic [31:0] msk,
                         input logic [31:0] wd, input logic [5:0] ad, output bit ok);
        int n;
        ok = 1'b0;
        @(negedge CLK);
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!op_ready) begin
            timeout("op_ready");
            return;
        end
        op_valid  = 1'b1;
        op_code   = op;
        comparand = cmp;
        mask      = msk;
        wdata     = wd;
        addr      = ad;
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1 op_valid = 1'b0;
        @(negedge CLK);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!rsp_valid) begin
            timeout("rsp_valid");
            return;
        end
        s_tags = tags;
        s_cnt  = int'(rsp_count);
        s_idx  = int'(rsp_index);
        s_any  = rsp_any;
        s_data = rsp_data;
        s_lat  = n;
        ok     = 1'b1;
    endtask

    initial begin
        bit ok;
        int n;

        //  op        cmp           mask          wdata         addr  tags                    cnt idx any data
        add(SET_ALL,  32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(READ,     32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(CLR_TAGS, 32'h0,        32'h0,        32'h0,        6'd0,  64'h0,                  0,  0,  0, 32'h0);
        add(LOAD,     32'h0,        32'h0,        32'h5,        6'd0,  64'h0,                  0,  0,  0, 32'h0);
        add(LOAD,     32'h0,        32'h0,        32'h7,        6'd1,  64'h0,                  0,  0,  0, 32'h0);
        add(LOAD,     32'h0,        32'h0,        32'h5,        6'd2,  64'h0,                  0,  0,  0, 32'h0);
        add(LOAD,     32'h0,        32'h0,        32'h9,        6'd3,  64'h0,                  0,  0,  0, 32'h0);
        add(SET_ALL,  32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(SEARCH,   32'h5,        32'hFFFF_FFFF,32'h0,        6'd0,  64'h5,                  2,  0,  1, 32'h0);
        add(SEL_FST,  32'h0,        32'h0,        32'h0,        6'd0,  64'h1,                  1,  0,  1, 32'h0);
        add(READ,     32'h0,        32'h0,        32'h0,        6'd0,  64'h1,                  1,  0,  1, 32'h5);
        add(SET_ALL,  32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(SEARCH,   32'hF,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(SEARCH,   32'h5,        32'hFFFF_FFFF,32'h0,        6'd0,  64'h5,                  2,  0,  1, 32'h0);
        add(WRITE,    32'h0,        32'hF0,       32'hF0,       6'd0,  64'h5,                  2,  0,  1, 32'h0);
        add(SET_ALL,  32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(SEARCH,   32'h5,        32'hF,        32'h0,        6'd0,  64'h5,                  2,  0,  1, 32'h0);
        add(READ,     32'h0,        32'h0,        32'h0,        6'd0,  64'h5,                  2,  0,  1, 32'hF5);
        add(SET_ALL,  32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(SEARCH,   32'h7,        32'hFFFF_FFFF,32'h0,        6'd0,  64'h2,                  1,  1,  1, 32'h0);
        add(READ,     32'h0,        32'h0,        32'h0,        6'd0,  64'h2,                  1,  1,  1, 32'h7);
        add(SET_ALL,  32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(SEARCH,   32'h9,        32'hFFFF_FFFF,32'h0,        6'd0,  64'h8,                  1,  3,  1, 32'h0);
        add(NOP,      32'h0,        32'h0,        32'h0,        6'd0,  64'h8,                  1,  3,  1, 32'h0);
        add(READ,     32'h0,        32'h0,        32'h0,        6'd0,  64'h8,                  1,  3,  1, 32'h9);
        add(CLR_TAGS, 32'h0,        32'h0,        32'h0,        6'd0,  64'h0,                  0,  0,  0, 32'h0);
        add(WRITE,    32'h0,        32'hFFFF_FFFF,32'hFFFF_FFFF,6'd0,  64'h0,                  0,  0,  0, 32'h0);
        add(SET_ALL,  32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(SEARCH,   32'h0,        32'hFFFF_FFFF,32'h0,        6'd0,  64'hFFFF_FFFF_FFFF_FFF0,60, 4,  1, 32'h0);
        add(SEL_FST,  32'h0,        32'h0,        32'h0,        6'd0,  64'h10,                 1,  4,  1, 32'h0);
        add(SET_ALL,  32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(SEARCH,   32'hF5,       32'hFFFF_FFFF,32'h0,        6'd0,  64'h5,                  2,  0,  1, 32'h0);
        add(LOAD,     32'h0,        32'h0,        32'hA5,       6'd63, 64'h5,                  2,  0,  1, 32'h0);
        add(SET_ALL,  32'h0,        32'h0,        32'h0,        6'd0,  ALL,                    64, 0,  1, 32'h0);
        add(SEARCH,   32'hA5,       32'hFFFF_FFFF,32'h0,        6'd0,  64'h8000_0000_0000_0000,1, 63, 1, 32'h0);
        add(READ,     32'h0,        32'h0,        32'h0,        6'd0,  64'h8000_0000_0000_0000,1, 63, 1, 32'hA5);

        RST       = 1'b1;
        op_valid  = 1'b0;
        op_code   = 3'd0;
        comparand = '0;
        mask      = '0;
        wdata     = '0;
        addr      = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("reset op_ready", 64'(op_ready), 64'd1);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset tags", tags, 64'd0);
        chk("reset rsp_count", 64'(rsp_count), 64'd0);
        chk("reset rsp_data", 64'(rsp_data), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].op, vecs[i].cmp, vecs[i].msk, vecs[i].wd, vecs[i].ad, ok);
            if (ok) begin
                chk($sformatf("v%0d latency", i), 64'(s_lat), 64'd1);
                chk($sformatf("v%0d tags", i), s_tags, vecs[i].e_tags);
                chk($sformatf("v%0d rsp_count", i), 64'(s_cnt), 64'(vecs[i].e_cnt));
                chk($sformatf("v%0d rsp_index", i), 64'(s_idx), 64'(vecs[i].e_idx));
                chk($sformatf("v%0d rsp_any", i), 64'(s_any), 64'(vecs[i].e_any));
                chk($sformatf("v%0d rsp_data", i), 64'(s_data), 64'(vecs[i].e_data));
            end
        end

        // Backpressure: tags hold bit 63 only; SEL_FST keeps it.
        @(negedge CLK);
        op_valid  = 1'b1;
        op_code   = SEL_FST;
        rsp_ready = 1'b0;
        @(posedge CLK);
        #1 op_valid = 1'b0;
        @(negedge CLK);
        chk("bp exec rsp_valid", 64'(rsp_valid), 64'd0);
        chk("bp exec op_ready", 64'(op_ready), 64'd0);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp%0d rsp_valid", k), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp%0d op_ready", k), 64'(op_ready), 64'd0);
            chk($sformatf("bp%0d rsp_index", k), 64'(rsp_index), 64'd63);
            chk($sformatf("bp%0d rsp_count", k), 64'(rsp_count), 64'd1);
            chk($sformatf("bp%0d tags", k), tags, 64'h8000_0000_0000_0000);
            if (k == 0) begin
                op_valid = 1'b1;
                op_code  = CLR_TAGS;
            end
            if (k == 3) begin
                rsp_ready = 1'b1;
            end
            @(negedge CLK);
        end
        chk("bp release rsp_valid", 64'(rsp_valid), 64'd0);
        chk("bp release op_ready", 64'(op_ready), 64'd1);
        chk("bp ignored op tags", tags, 64'h8000_0000_0000_0000);
        @(posedge CLK);
        #1 op_valid = 1'b0;
        @(negedge CLK);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!rsp_valid) begin
            timeout("bp held op rsp_valid");
        end else begin
            chk("bp held op tags", tags, 64'd0);
        end

        // Reset during EXEC of a WRITE to every cell.
        do_op(SET_ALL, 32'h0, 32'h0, 32'h0, 6'd0, ok);
        @(negedge CLK);
        op_valid  = 1'b1;
        op_code   = WRITE;
        mask      = 32'hFFFF_FFFF;
        wdata     = 32'hFFFF_FFFF;
        @(posedge CLK);
        #1 op_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst exec rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst exec op_ready", 64'(op_ready), 64'd1);
        chk("rst exec tags", tags, 64'd0);
        @(negedge CLK);
        chk("rst exec no rsp", 64'(rsp_valid), 64'd0);
        do_op(SET_ALL, 32'h0, 32'h0, 32'h0, 6'd0, ok);
        do_op(SEARCH, 32'h0, 32'hFFFF_FFFF, 32'h0, 6'd0, ok);
        if (ok) begin
            chk("rst cells zero tags", s_tags, ALL);
            chk("rst cells zero count", 64'(s_cnt), 64'd64);
        end
        do_op(READ, 32'h0, 32'h0, 32'h0, 6'd0, ok);
        if (ok) begin
            chk("rst cell0 data", 64'(s_data), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
